mem_bus_arbiter: RTL and testbench
==================================

Name: mem_bus_arbiter

Overview:
- Shares the single memory0 port (en/rw/m_size/abus/dbus) between two bus masters: master 0 (cpu0 data/fetch path) and master 1 (DMA / flash loader).
- Round-robin arbitration, optional master-0 lock, fixed-latency access sequencing, write-only IO port decode at IOADDR, and out-of-range error response.
- Sits between the cpu0/DMA request ports and memory0 in the main testbench/SoC top.

Parameters:
- MEMSIZE, 'h80000, memory byte size; legal memory addresses 0..MEMSIZE-4.
- IOADDR, 'h80000, IO-mapped output address; writes here go to the IO port, not memory.
- MEM_LAT, 1, cycles mem_en is held high per access (1..15).

Ports:
- clock  in  1  system clock, all state on posedge
- reset  in  1  synchronous, active-high
- mN_req  in  1  request (N=0,1); held stable until mN_ack
- mN_rw  in  1  1=read, 0=write
- mN_size  in  2  BYTE=00, INT16=01, INT24=10, INT32=11
- mN_addr  in  32  byte address
- mN_wdata  in  32  write data
- mN_rdata  out  32  read data, valid in ack cycle
- mN_ack  out  1  one-cycle completion pulse
- mN_err  out  1  asserted with ack when address is illegal
- m0_lock  in  1  keep grant on master 0 for back-to-back transfers
- mem_en, mem_rw  out  1  memory enable / direction
- mem_size  out  2  memory operand size
- mem_addr, mem_wdata  out  32  memory address / write data
- mem_rdata  in  32  memory read data
- io_wr  out  1  one-cycle IO write strobe
- io_wdata  out  32  IO write data
- io_size  out  2  IO write size
- gnt  out  1  id of current/last granted master
- busy  out  1  high in any state except IDLE

Behaviour:
- Reset: state=IDLE; all outputs 0; rr pointer prefers master 0 next.
- States: IDLE, ACCESS, DONE.
- IDLE:
  - If any req is high, pick a winner:
    - Both requesting: winner = rr-preferred master.
    - m0_lock high and the last grant was 0: master 0 wins.
  - Latch rw, size, addr and wdata into registers; set gnt.
  - Legal memory address: drive mem_* and mem_en=1, load counter=MEM_LAT, go to ACCESS.
  - Write with addr==IOADDR: pulse io_wr with io_wdata/io_size, go to DONE.
  - Anything else (IOADDR read, or addr>MEMSIZE-4 and not IOADDR): go to DONE with err flag set; no mem_en, no io_wr.
- ACCESS:
  - Decrement counter each cycle; mem_* outputs stay stable.
  - When the counter reaches 1, capture mem_rdata into the winner's rdata (reads only), drop mem_en, go to DONE.
- DONE:
  - Pulse the winner's ack for one cycle; err is valid in the same cycle.
  - Update rr pointer to the other master, unless m0_lock holds with winner 0.
  - Go to IDLE.
- Latency, req sampled in cycle T:
  - Memory access: mem_en high T+1..T+MEM_LAT; ack in T+MEM_LAT+1.
  - IO or error: ack in T+2.
  - Throughput: one transaction per MEM_LAT+2 cycles.
- A dropped req after grant does not abort the access; it completes and still acks.
- A req dropped before grant is ignored.
- The loser's req waits; no starvation: with both requesting continuously, grants alternate (except under lock).
- m0_lock while master 0 is idle has no effect; master 1 is granted.
- rdata holds its last value until the next read ack to that master; error reads return 0.
- mem_wdata and io_wdata are forced to 0 on reads.
- Reset mid-ACCESS: mem_en=0 next cycle, no ack, state=IDLE.
- Size ignored for the address legality check (MEMSIZE-4 bound applies to all sizes).

Decomposition:
- Shared package (cpu0_pkg): size codes BYTE/INT16/INT24/INT32, MEMSIZE, IOADDR, state encodings IDLE/ACCESS/DONE.
- One sub-module, rr_arb2: 2-way round-robin/lock grant logic.
- Datapath latching and the FSM stay in mem_bus_arbiter.

Test Plan:
- M0 INT32 read of addr 0x100 (memory holds 0x01020304), MEM_LAT=1 -> mem_en one cycle, m0_ack at T+2, m0_rdata=0x01020304, m0_err=0.
- M0 and M1 request simultaneously and continuously, MEM_LAT=2 -> grants 0,1,0,1; acks every 4 cycles alternating; gnt toggles.
- m0_lock=1, both requesting -> four consecutive master-0 acks; drop lock -> next grant is master 1.
- M1 BYTE write 0x41 to IOADDR -> io_wr pulse with io_wdata[7:0]=0x41, io_size=00, mem_en never high, m1_ack at T+2.
- M0 read of 0x7FFFD (>MEMSIZE-4) -> m0_ack+m0_err at T+2, m0_rdata=0, no mem_en.
- Reset asserted during ACCESS with MEM_LAT=3 -> mem_en low next cycle, no ack, busy=0; fresh request then completes normally.

Source files
------------

// File: rtl/cpu0_pkg.sv
// Shared definitions for the cpu0 memory subsystem: operand sizes, memory map
// and memory-arbiter state encodings.
package cpu0_pkg;

   typedef enum logic [1:0] {
      BYTE  = 2'b00,
      INT16 = 2'b01,
      INT24 = 2'b10,
      INT32 = 2'b11
   } size_e;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      DONE   = 2'd2
   } state_e;

   localparam logic [31:0] MEMSIZE = 32'h0008_0000;
   localparam logic [31:0] IOADDR  = 32'h0008_0000;

   // Operand size is deliberately ignored: the last word-aligned slot bounds every access.
   function automatic logic is_mem_addr(input logic [31:0] addr,
                                        input logic [31:0] memsize,
                                        input logic [31:0] ioaddr);
      return (addr != ioaddr) && (addr <= memsize - 32'd4);
   endfunction

endpackage

// File: rtl/mem_bus_arbiter_rr_arb2.sv
// Two-way round-robin grant with an optional master-0 lock.
module rr_arb2 (
   input  logic       clock,
   input  logic       reset,
   input  logic [1:0] req_i,
   input  logic       lock_i,
   input  logic       last_gnt_i,
   input  logic       upd_i,
   output logic       gnt_valid_o,
   output logic       gnt_id_o
);

   logic rr_q;
   logic lock_hold;

   assign lock_hold = lock_i && !last_gnt_i;

   always_comb begin
      gnt_valid_o = |req_i;
      gnt_id_o    = req_i[1] & ~req_i[0];
      if (&req_i) begin
         gnt_id_o = lock_hold ? 1'b0 : rr_q;
      end
   end

   // The pointer only moves when a transfer finishes, and stays on master 0 while it is locked.
   always_ff @(posedge clock) begin
      if (reset) begin
         rr_q <= 1'b0;
      end else if (upd_i && !lock_hold) begin
         rr_q <= ~last_gnt_i;
      end
   end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares the memory0 port between cpu0 (master 0) and the DMA/loader (master 1),
// with IO write decode and out-of-range error response.
module mem_bus_arbiter #(
   parameter logic [31:0] MEMSIZE = cpu0_pkg::MEMSIZE,
   parameter logic [31:0] IOADDR  = cpu0_pkg::IOADDR,
   parameter int unsigned MEM_LAT = 1
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        m0_req,
   input  logic        m0_rw,
   input  logic [1:0]  m0_size,
   input  logic [31:0] m0_addr,
   input  logic [31:0] m0_wdata,
   output logic [31:0] m0_rdata,
   output logic        m0_ack,
   output logic        m0_err,
   input  logic        m0_lock,
   input  logic        m1_req,
   input  logic        m1_rw,
   input  logic [1:0]  m1_size,
   input  logic [31:0] m1_addr,
   input  logic [31:0] m1_wdata,
   output logic [31:0] m1_rdata,
   output logic        m1_ack,
   output logic        m1_err,
   output logic        mem_en,
   output logic        mem_rw,
   output logic [1:0]  mem_size,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata,
   output logic        io_wr,
   output logic [31:0] io_wdata,
   output logic [1:0]  io_size,
   output logic        gnt,
   output logic        busy
);
   import cpu0_pkg::*;

   localparam logic [3:0] LAT = 4'(MEM_LAT);

   state_e      state_q;
   logic [3:0]  cnt_q;
   logic        rw_q, err_q, gnt_q;
   logic        mem_en_q, mem_rw_q, io_wr_q;
   logic [1:0]  mem_size_q, io_size_q;
   logic [31:0] mem_addr_q, mem_wdata_q, io_wdata_q;
   logic [31:0] m0_rdata_q, m1_rdata_q;
   logic        m0_ack_q, m1_ack_q, m0_err_q, m1_err_q;

   logic        arb_valid, arb_id;
   logic        sel_rw;
   logic [1:0]  sel_size;
   logic [31:0] sel_addr, sel_wdata;
   logic        sel_mem, sel_io;

   rr_arb2 u_arb (
      .clock       (clock),
      .reset       (reset),
      .req_i       ({m1_req, m0_req}),
      .lock_i      (m0_lock),
      .last_gnt_i  (gnt_q),
      .upd_i       (state_q == DONE),
      .gnt_valid_o (arb_valid),
      .gnt_id_o    (arb_id)
   );

   always_comb begin
      sel_rw    = arb_id ? m1_rw    : m0_rw;
      sel_size  = arb_id ? m1_size  : m0_size;
      sel_addr  = arb_id ? m1_addr  : m0_addr;
      sel_wdata = arb_id ? m1_wdata : m0_wdata;
      sel_mem   = is_mem_addr(sel_addr, MEMSIZE, IOADDR);
      sel_io    = !sel_rw && (sel_addr == IOADDR);
   end

   // IO and error responses spend one ACCESS beat with mem_en low so their ack
   // lands two cycles after the request, the same as a single-cycle memory access.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         rw_q        <= 1'b0;
         err_q       <= 1'b0;
         gnt_q       <= 1'b0;
         mem_en_q    <= 1'b0;
         mem_rw_q    <= 1'b0;
         mem_size_q  <= '0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         io_wr_q     <= 1'b0;
         io_size_q   <= '0;
         io_wdata_q  <= '0;
         m0_rdata_q  <= '0;
         m1_rdata_q  <= '0;
         m0_ack_q    <= 1'b0;
         m1_ack_q    <= 1'b0;
         m0_err_q    <= 1'b0;
         m1_err_q    <= 1'b0;
      end else begin
         io_wr_q  <= 1'b0;
         m0_ack_q <= 1'b0;
         m1_ack_q <= 1'b0;
         m0_err_q <= 1'b0;
         m1_err_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (arb_valid) begin
                  gnt_q   <= arb_id;
                  rw_q    <= sel_rw;
                  err_q   <= !(sel_mem || sel_io);
                  state_q <= ACCESS;
                  cnt_q   <= 4'd1;
                  if (sel_mem) begin
                     mem_en_q    <= 1'b1;
                     mem_rw_q    <= sel_rw;
                     mem_size_q  <= sel_size;
                     mem_addr_q  <= sel_addr;
                     mem_wdata_q <= sel_rw ? 32'd0 : sel_wdata;
                     cnt_q       <= LAT;
                  end else if (sel_io) begin
                     io_wr_q    <= 1'b1;
                     io_wdata_q <= sel_wdata;
                     io_size_q  <= sel_size;
                  end
               end
            end
            ACCESS: begin
               if (cnt_q <= 4'd1) begin
                  mem_en_q <= 1'b0;
                  state_q  <= DONE;
                  if (gnt_q) begin
                     m1_ack_q <= 1'b1;
                     m1_err_q <= err_q;
                     if (rw_q) m1_rdata_q <= err_q ? 32'd0 : mem_rdata;
                  end else begin
                     m0_ack_q <= 1'b1;
                     m0_err_q <= err_q;
                     if (rw_q) m0_rdata_q <= err_q ? 32'd0 : mem_rdata;
                  end
               end else begin
                  cnt_q <= cnt_q - 4'd1;
               end
            end
            DONE:    state_q <= IDLE;
            default: state_q <= IDLE;
         endcase
      end
   end

   assign m0_rdata  = m0_rdata_q;
   assign m1_rdata  = m1_rdata_q;
   assign m0_ack    = m0_ack_q;
   assign m1_ack    = m1_ack_q;
   assign m0_err    = m0_err_q;
   assign m1_err    = m1_err_q;
   assign mem_en    = mem_en_q;
   assign mem_rw    = mem_rw_q;
   assign mem_size  = mem_size_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
   assign io_wr     = io_wr_q;
   assign io_wdata  = io_wdata_q;
   assign io_size   = io_size_q;
   assign gnt       = gnt_q;
   assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Scoreboard bench for mem_bus_arbiter: expected acks are queued as requests are
// driven and compared when each ack appears.
module tb_mem_bus_arbiter;
   import cpu0_pkg::*;

   localparam int          LAT = 3;
   localparam logic [31:0] MSZ = 32'h0008_0000;
   localparam logic [31:0] IOA = 32'h0008_0000;

   logic        clock = 1'b0;
   logic        reset;
   logic        m0_req, m0_rw, m0_lock, m1_req, m1_rw;
   logic [1:0]  m0_size, m1_size;
   logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
   logic [31:0] m0_rdata, m1_rdata;
   logic        m0_ack, m0_err, m1_ack, m1_err;
   logic        mem_en, mem_rw, io_wr, gnt, busy;
   logic [1:0]  mem_size, io_size;
   logic [31:0] mem_addr, mem_wdata, mem_rdata, io_wdata;

   mem_bus_arbiter #(.MEMSIZE(MSZ), .IOADDR(IOA), .MEM_LAT(LAT)) dut (
      .clock(clock), .reset(reset),
      .m0_req(m0_req), .m0_rw(m0_rw), .m0_size(m0_size), .m0_addr(m0_addr),
      .m0_wdata(m0_wdata), .m0_rdata(m0_rdata), .m0_ack(m0_ack), .m0_err(m0_err),
      .m0_lock(m0_lock),
      .m1_req(m1_req), .m1_rw(m1_rw), .m1_size(m1_size), .m1_addr(m1_addr),
      .m1_wdata(m1_wdata), .m1_rdata(m1_rdata), .m1_ack(m1_ack), .m1_err(m1_err),
      .mem_en(mem_en), .mem_rw(mem_rw), .mem_size(mem_size), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
      .io_wr(io_wr), .io_wdata(io_wdata), .io_size(io_size),
      .gnt(gnt), .busy(busy)
   );

   always #5 clock = ~clock;

   int cyc = 0;
   always @(posedge clock) cyc <= cyc + 1;

   function automatic logic [31:0] mem_model(input logic [31:0] a);
      return (a == 32'h100) ? 32'h0102_0304 : {a[15:0] ^ 16'h5A5A, a[15:0]};
   endfunction

   assign mem_rdata = mem_model(mem_addr);

   int n_chk  = 0;
   int n_fail = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   typedef struct {
      logic        m;
      logic [31:0] rdata;
      logic        err;
   } exp_t;

   exp_t        sb_q[$];
   logic [31:0] last_rd[2] = '{32'd0, 32'd0};

   function automatic logic legal(input logic [31:0] a);
      return (a != IOA) && (a <= MSZ - 32'd4);
   endfunction

   function automatic void push_exp(input logic m, input logic rw, input logic [31:0] a);
      exp_t e;
      logic is_io;
      is_io = !rw && (a == IOA);
      e.m   = m;
      e.err = !(legal(a) || is_io);
      if (rw) last_rd[m] = e.err ? 32'd0 : mem_model(a);
      e.rdata = last_rd[m];
      sb_q.push_back(e);
   endfunction

   task automatic drive(input logic m, input logic req, input logic rw, input logic [1:0] sz,
                        input logic [31:0] a, input logic [31:0] wd);
      if (m) begin
         m1_req = req; m1_rw = rw; m1_size = sz; m1_addr = a; m1_wdata = wd;
      end else begin
         m0_req = req; m0_rw = rw; m0_size = sz; m0_addr = a; m0_wdata = wd;
      end
   endtask

   always @(negedge clock) begin
      exp_t e;
      if (!reset && (m0_ack || m1_ack)) begin
         check_eq("ack_both", 32'(m0_ack & m1_ack), 32'd0);
         if (sb_q.size() == 0) begin
            check_eq("unexpected_ack_sb_depth", 32'(sb_q.size()), 32'd1);
         end else begin
            e = sb_q.pop_front();
            check_eq("ack_master", 32'(m1_ack), 32'(e.m));
            check_eq("gnt_at_ack", 32'(gnt), 32'(e.m));
            check_eq("rdata", m1_ack ? m1_rdata : m0_rdata, e.rdata);
            check_eq("err", 32'(m1_ack ? m1_err : m0_err), 32'(e.err));
         end
      end
   end

   task automatic run_single(input logic m, input logic rw, input logic [1:0] sz,
                             input logic [31:0] a, input logic [31:0] wd, input string tag);
      int   t0, en_cnt, io_cnt;
      logic got, is_io, is_mem;
      is_io  = !rw && (a == IOA);
      is_mem = legal(a);
      push_exp(m, rw, a);
      @(negedge clock);
      drive(m, 1'b1, rw, sz, a, wd);
      t0 = cyc; en_cnt = 0; io_cnt = 0; got = 1'b0;
      for (int i = 0; i < 20 && !got; i++) begin
         @(negedge clock);
         if (mem_en) begin
            en_cnt++;
            if (en_cnt == 1) begin
               check_eq({tag, "_mem_addr"}, mem_addr, a);
               check_eq({tag, "_mem_wdata"}, mem_wdata, rw ? 32'd0 : wd);
               check_eq({tag, "_mem_rw"}, 32'(mem_rw), 32'(rw));
            end
         end
         if (io_wr) begin
            io_cnt++;
            check_eq({tag, "_io_wdata"}, io_wdata, wd);
            check_eq({tag, "_io_size"}, 32'(io_size), 32'(sz));
         end
         if (m ? m1_ack : m0_ack) begin
            got = 1'b1;
            check_eq({tag, "_latency"}, 32'(cyc - t0), is_mem ? 32'(LAT + 1) : 32'd2);
            drive(m, 1'b0, rw, sz, a, wd);
         end
      end
      check_eq({tag, "_ack_seen"}, 32'(got), 32'd1);
      check_eq({tag, "_mem_en_cycles"}, 32'(en_cnt), is_mem ? 32'(LAT) : 32'd0);
      check_eq({tag, "_io_wr_pulses"}, 32'(io_cnt), is_io ? 32'd1 : 32'd0);
   endtask

   // Both masters request continuously; checks first-ack latency and ack spacing.
   task automatic run_both(input int n_acks, input int unlock_at, input string tag);
      int t0, prev, k;
      @(negedge clock);
      m0_req = 1'b1; m1_req = 1'b1;
      t0 = cyc; prev = 0; k = 0;
      for (int i = 0; i < 80 && k < n_acks; i++) begin
         @(negedge clock);
         if (m0_ack || m1_ack) begin
            if (k == 0) check_eq({tag, "_first_latency"}, 32'(cyc - t0), 32'(LAT + 1));
            else        check_eq({tag, "_ack_spacing"}, 32'(cyc - prev), 32'(LAT + 2));
            prev = cyc;
            k++;
            if (k == unlock_at) m0_lock = 1'b0;
            if (k == n_acks) begin m0_req = 1'b0; m1_req = 1'b0; end
         end
      end
      check_eq({tag, "_ack_count"}, 32'(k), 32'(n_acks));
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached, n_fail=%0d", n_fail);
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1; m0_lock = 1'b0;
      drive(1'b0, 1'b0, 1'b0, BYTE, 32'd0, 32'd0);
      drive(1'b1, 1'b0, 1'b0, BYTE, 32'd0, 32'd0);
      repeat (3) @(negedge clock);
      check_eq("rst_mem_en",  32'(mem_en), 32'd0);
      check_eq("rst_io_wr",   32'(io_wr),  32'd0);
      check_eq("rst_busy",    32'(busy),   32'd0);
      check_eq("rst_gnt",     32'(gnt),    32'd0);
      check_eq("rst_acks",    32'({m0_ack, m1_ack}), 32'd0);
      check_eq("rst_m0_rdata", m0_rdata, 32'd0);
      check_eq("rst_mem_addr", mem_addr, 32'd0);
      reset = 1'b0;

      // Alternating grants from reset: pointer prefers master 0 first.
      drive(1'b0, 1'b0, 1'b1, INT32, 32'h10, 32'd0);
      drive(1'b1, 1'b0, 1'b1, INT32, 32'h20, 32'd0);
      for (int i = 0; i < 2; i++) begin
         push_exp(1'b0, 1'b1, 32'h10);
         push_exp(1'b1, 1'b1, 32'h20);
      end
      run_both(4, 0, "alt");

      run_single(1'b0, 1'b1, INT32, 32'h100, 32'd0, "rd100");

      // Locked master 0 after its own grant, then release hands over to master 1.
      m0_lock = 1'b1;
      drive(1'b0, 1'b0, 1'b1, INT32, 32'h104, 32'd0);
      drive(1'b1, 1'b0, 1'b0, INT32, 32'h200, 32'hDEAD_0001);
      for (int i = 0; i < 4; i++) push_exp(1'b0, 1'b1, 32'h104);
      push_exp(1'b1, 1'b0, 32'h200);
      run_both(5, 4, "lock");

      m0_lock = 1'b1;
      run_single(1'b1, 1'b1, INT32, 32'h300, 32'd0, "lock_m0_idle");
      m0_lock = 1'b0;

      run_single(1'b1, 1'b0, BYTE,  IOA,           32'h41,   "io_wr");
      run_single(1'b0, 1'b1, INT32, 32'h0007_FFFD, 32'd0,    "rd_oob");
      run_single(1'b0, 1'b1, INT32, 32'h0007_FFFC, 32'd0,    "rd_edge");
      run_single(1'b1, 1'b1, INT32, IOA,           32'd0,    "io_rd_err");
      run_single(1'b0, 1'b0, INT16, 32'h0009_0000, 32'h1234, "wr_oob");
      run_single(1'b0, 1'b0, INT16, 32'h204,       32'hCAFE, "wr_mem");

      // Reset in the middle of a memory access: aborted, no ack.
      @(negedge clock);
      drive(1'b0, 1'b1, 1'b1, INT32, 32'h400, 32'd0);
      @(negedge clock);
      check_eq("rstmid_mem_en_before", 32'(mem_en), 32'd1);
      @(negedge clock);
      reset = 1'b1;
      drive(1'b0, 1'b0, 1'b1, INT32, 32'h400, 32'd0);
      @(negedge clock);
      check_eq("rstmid_mem_en_after", 32'(mem_en), 32'd0);
      check_eq("rstmid_busy",         32'(busy),   32'd0);
      check_eq("rstmid_no_ack",       32'({m0_ack, m1_ack}), 32'd0);
      reset = 1'b0;
      last_rd[0] = 32'd0;
      last_rd[1] = 32'd0;
      run_single(1'b0, 1'b1, INT32, 32'h100, 32'd0, "post_rst_rd");

      repeat (3) @(negedge clock);
      check_eq("sb_drained", 32'(sb_q.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
